// File: rtl/bcd2bin.sv
// bcd2bin -- multi-cycle BCD-to-binary converter (reverse double-dabble).
//
// Accepts DIGITS packed BCD digits and returns the unsigned binary value.
// Each SHIFT cycle moves the {bcd, bin} register pair one bit to the right.
// After that move, every BCD nibble that reads >= 8 has 3 subtracted.
// A conversion takes 4*DIGITS shift cycles plus one FINISH cycle.
// The start/done handshake mirrors bin2BCD, so the two can be chained.
//
// Ports
//   clk      in   1      rising-edge clock
//   rst      in   1      synchronous active-high reset; aborts a running conversion
//   start    in   1      conversion request, sampled only while idle
//   dig1000  in   4      thousands digit
//   dig100   in   4      hundreds digit
//   dig10    in   4      tens digit
//   dig1     in   4      units digit
//   bin      out  BIN_W  result, held until the next completion
//   busy     out  1      high while shifting
//   done     out  1      one-cycle pulse when bin/err are updated
//   err      out  1      last accepted request contained a digit > 9
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       dig1000,
  input  logic [3:0]       dig100,
  input  logic [3:0]       dig10,
  input  logic [3:0]       dig1,
  output logic [BIN_W-1:0] bin,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = $clog2(SR_W) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SR_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FINISH} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [SR_W-1:0]     r_bcd_sr;
  logic [SR_W-1:0]     r_bin_sr;
  logic [CNT_W-1:0]    r_cnt;
  logic [BIN_W-1:0]    r_bin;
  logic                r_busy;
  logic                r_done;
  logic                r_err;

  logic [3:0]          w_dig [4];
  logic [SR_W-1:0]     w_bcd_in;
  logic                w_bad;
  logic [2*SR_W-1:0]   w_step;
  logic                w_load;
  logic                w_reject;
  logic                w_shift;
  logic                w_last;
  logic                w_finish;

  // One reverse double-dabble iteration: shift right, then pull every
  // nibble that crossed into the 8..15 range back down by 3.
  function automatic logic [2*SR_W-1:0] dabble_step(input logic [2*SR_W-1:0] v);
    logic [2*SR_W-1:0] s;
    s = v >> 1;
    for (int d = 0; d < DIGITS; d++) begin
      if (s[SR_W + 4*d +: 4] >= 4'd8)
        s[SR_W + 4*d +: 4] = s[SR_W + 4*d +: 4] - 4'd3;
    end
    return s;
  endfunction

  assign w_dig[0] = dig1;
  assign w_dig[1] = dig10;
  assign w_dig[2] = dig100;
  assign w_dig[3] = dig1000;

  // Pack the digit ports into the BCD register image and flag any non-decimal nibble.
  always_comb begin
    w_bcd_in = '0;
    w_bad    = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i < DIGITS) begin
        w_bcd_in[4*i +: 4] = w_dig[i];
        if (w_dig[i] > 4'd9) w_bad = 1'b1;
      end
    end
  end

  assign w_step = dabble_step({r_bcd_sr, r_bin_sr});

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // FSM next-state logic; a rejected request completes in IDLE without shifting
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   if (start && !w_bad) w_state_nxt = S_SHIFT;
      S_SHIFT:  if (r_cnt == LAST_CNT) w_state_nxt = S_FINISH;
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // FSM output decode: datapath strobes
  always_comb begin
    w_load   = 1'b0;
    w_reject = 1'b0;
    w_shift  = 1'b0;
    w_last   = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_load   = start && !w_bad;
        w_reject = start &&  w_bad;
      end
      S_SHIFT: begin
        w_shift = 1'b1;
        w_last  = (r_cnt == LAST_CNT);
      end
      S_FINISH: w_finish = 1'b1;
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bcd_sr <= '0;
      r_bin_sr <= '0;
      r_cnt    <= '0;
      r_bin    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_reject) begin
        r_bin  <= '0;
        r_err  <= 1'b1;
        r_done <= 1'b1;
      end
      if (w_load) begin
        r_err    <= 1'b0;
        r_bcd_sr <= w_bcd_in;
        r_bin_sr <= '0;
        r_cnt    <= '0;
        r_busy   <= 1'b1;
      end
      if (w_shift) begin
        {r_bcd_sr, r_bin_sr} <= w_step;
        r_cnt                <= r_cnt + 1'b1;
        // busy covers exactly the shift cycles, so it drops on entry to FINISH
        if (w_last) r_busy <= 1'b0;
      end
      if (w_finish) begin
        r_bin  <= BIN_W'(r_bin_sr);
        r_done <= 1'b1;
        r_busy <= 1'b0;
      end
    end
  end

  assign bin  = r_bin;
  assign busy = r_busy;
  assign done = r_done;
  assign err  = r_err;

endmodule
